// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the in-place radix-2 DIT FFT sequencer.
//   state_e : controller FSM encoding (IDLE must stay at zero so reset clears it)
//   FFT_N / FFT_LOG2N : default transform size
//   clog2   : constant-evaluable ceil(log2(v)), used for port/counter widths
package fft_pkg;

   localparam int FFT_N     = 16;
   localparam int FFT_LOG2N = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: combinational butterfly address / twiddle generator.
//   i_stage  : stage s (0..LOG2N-1)
//   i_bfly   : butterfly b within the stage (0..N/2-1)
//   o_addr0  : upper leg address  grp*2*span + pos
//   o_addr1  : lower leg address  o_addr0 + span
//   o_tw_idx : twiddle exponent   pos << (LOG2N-1-s)
// with span = 1<<s, grp = b>>s, pos = b & (span-1).
module fft_addr_gen
   import fft_pkg::*;
#(
   parameter int LOG2N  = FFT_LOG2N,
   parameter int ADDR_W = LOG2N,
   parameter int TW_W   = LOG2N - 1,
   parameter int ST_W   = clog2(LOG2N)
) (
   input  logic [ST_W-1:0]   i_stage,
   input  logic [TW_W-1:0]   i_bfly,
   output logic [ADDR_W-1:0] o_addr0,
   output logic [ADDR_W-1:0] o_addr1,
   output logic [TW_W-1:0]   o_tw_idx
);

   logic [ADDR_W-1:0] b_ext, span, grp, pos, a0, tw_full;

   always_comb begin
      b_ext   = ADDR_W'(i_bfly);
      span    = ADDR_W'(1) << i_stage;
      grp     = b_ext >> i_stage;
      pos     = b_ext & (span - ADDR_W'(1));
      // grp*2*span is a left shift by s+1; pos < span so OR is an add
      a0      = (grp << (i_stage + 1'b1)) | pos;
      tw_full = pos << (ADDR_W'(TW_W) - ADDR_W'(i_stage));
   end

   assign o_addr0  = a0;
   assign o_addr1  = a0 + span;
   assign o_tw_idx = tw_full[TW_W-1:0];

endmodule

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: walks one butterfly2 datapath through all N/2*LOG2N
// butterflies of an in-place radix-2 DIT FFT (bit-reversed in, natural out).
//   i_clk, i_rst      : clock, async active-high reset (aborts a run, no write)
//   i_start           : start request, only looked at in IDLE
//   i_bf_done         : butterfly result ready, only looked at in WAIT
//   o_bf_start        : one-cycle operand-valid pulse to butterfly2
//   o_rd_addr0/1      : RAM read addresses (valid during READ, held after)
//   o_wr_addr0/1      : RAM write addresses, captured at ISSUE
//   o_we              : one-cycle write strobe for both legs
//   o_tw_idx          : twiddle ROM index k of W_N^k
//   o_stage           : current stage
//   o_busy / o_done   : run in progress / one-cycle completion pulse
//   o_error           : sticky butterfly timeout, cleared by next start
// Every output is a flop loaded from the next-state decode.
module fft_stage_ctrl
   import fft_pkg::*;
#(
   parameter  int N       = FFT_N,
   parameter  int LOG2N   = FFT_LOG2N,
   parameter  int ADDR_W  = LOG2N,
   parameter  int TW_W    = LOG2N - 1,
   parameter  int TIMEOUT = 64,
   localparam int ST_W    = clog2(LOG2N)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_bf_done,
   output logic              o_bf_start,
   output logic [ADDR_W-1:0] o_rd_addr0,
   output logic [ADDR_W-1:0] o_rd_addr1,
   output logic [ADDR_W-1:0] o_wr_addr0,
   output logic [ADDR_W-1:0] o_wr_addr1,
   output logic              o_we,
   output logic [TW_W-1:0]   o_tw_idx,
   output logic [ST_W-1:0]   o_stage,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error
);

   localparam int CW = clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [ST_W-1:0]   s_q, s_d;
   logic [TW_W-1:0]   b_q, b_d;
   logic [CW-1:0]     wcnt_q, wcnt_d;
   logic              err_q, err_d;
   logic              bf_start_q, bf_start_d, we_q, we_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [ADDR_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d, wr0_q, wr0_d, wr1_q, wr1_d;
   logic [TW_W-1:0]   tw_q, tw_d;
   logic [ADDR_W-1:0] gen_a0, gen_a1;
   logic [TW_W-1:0]   gen_tw;
   logic              last_b, last_s;

   assign last_b = (b_q == TW_W'(N/2 - 1));
   assign last_s = (s_q == ST_W'(LOG2N - 1));

   // FSM and (s,b) counters
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      b_d     = b_q;
      wcnt_d  = wcnt_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: if (i_start) begin
            err_d   = 1'b0;
            s_d     = '0;
            b_d     = '0;
            state_d = ST_READ;
         end
         ST_READ:  state_d = ST_ISSUE;
         ST_ISSUE: begin
            wcnt_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // done is tested first so it wins over a coincident timeout
            if (i_bf_done) begin
               state_d = ST_WRITE;
            end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         ST_WRITE: begin
            state_d = ST_READ;
            if (last_b) begin
               b_d = '0;
               // stage stays at LOG2N-1 after the final butterfly
               if (last_s) state_d = ST_DONE;
               else        s_d     = s_q + 1'b1;
            end else begin
               b_d = b_q + 1'b1;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Addresses for the butterfly about to be read, so they land on the
   // output flops in the READ cycle itself.
   fft_addr_gen #(
      .LOG2N  (LOG2N),
      .ADDR_W (ADDR_W),
      .TW_W   (TW_W),
      .ST_W   (ST_W)
   ) u_addr_gen (
      .i_stage  (s_d),
      .i_bfly   (b_d),
      .o_addr0  (gen_a0),
      .o_addr1  (gen_a1),
      .o_tw_idx (gen_tw)
   );

   // Registered outputs decoded from the next state
   always_comb begin
      bf_start_d = (state_d == ST_ISSUE);
      we_d       = (state_d == ST_WRITE);
      done_d     = (state_d == ST_DONE);
      busy_d     = (state_d != ST_IDLE);
      rd0_d      = rd0_q;
      rd1_d      = rd1_q;
      tw_d       = tw_q;
      wr0_d      = wr0_q;
      wr1_d      = wr1_q;
      if (state_d == ST_READ) begin
         rd0_d = gen_a0;
         rd1_d = gen_a1;
         tw_d  = gen_tw;
      end
      if (state_d == ST_ISSUE) begin
         wr0_d = rd0_q;
         wr1_d = rd1_q;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         s_q        <= '0;
         b_q        <= '0;
         wcnt_q     <= '0;
         err_q      <= 1'b0;
         bf_start_q <= 1'b0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd0_q      <= '0;
         rd1_q      <= '0;
         wr0_q      <= '0;
         wr1_q      <= '0;
         tw_q       <= '0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         b_q        <= b_d;
         wcnt_q     <= wcnt_d;
         err_q      <= err_d;
         bf_start_q <= bf_start_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd0_q      <= rd0_d;
         rd1_q      <= rd1_d;
         wr0_q      <= wr0_d;
         wr1_q      <= wr1_d;
         tw_q       <= tw_d;
      end
   end

   assign o_bf_start = bf_start_q;
   assign o_we       = we_q;
   assign o_done     = done_q;
   assign o_busy     = busy_q;
   assign o_error    = err_q;
   assign o_stage    = s_q;
   assign o_rd_addr0 = rd0_q;
   assign o_rd_addr1 = rd1_q;
   assign o_wr_addr0 = wr0_q;
   assign o_wr_addr1 = wr1_q;
   assign o_tw_idx   = tw_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl with a one-cycle butterfly model.
module tb_fft_stage_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       bf_done;
   logic       bf_model = 1'b0;
   logic       bf_extra;
   int         mode;
   logic       bf_start, we, busy, done, err;
   logic [3:0] rd0, rd1, wr0, wr1;
   logic [2:0] tw;
   logic [1:0] stage;

   int n_chk = 0;
   int n_fail = 0;

   // monitor logs
   int         bs_cnt = 0, we_cnt = 0, dn_cnt = 0;
   logic [3:0] rd0_log [512];
   logic [3:0] rd1_log [512];
   logic [2:0] tw_log  [512];
   logic [3:0] wr0_log [512];
   logic [3:0] wr1_log [512];

   always #5 clk = ~clk;

   fft_stage_ctrl dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_bf_done  (bf_done),
      .o_bf_start (bf_start),
      .o_rd_addr0 (rd0),
      .o_rd_addr1 (rd1),
      .o_wr_addr0 (wr0),
      .o_wr_addr1 (wr1),
      .o_we       (we),
      .o_tw_idx   (tw),
      .o_stage    (stage),
      .o_busy     (busy),
      .o_done     (done),
      .o_error    (err)
   );

   // butterfly model: done one cycle after start (mode 1), never (mode 0)
   always @(posedge clk) bf_model <= (mode == 1) && bf_start;
   assign bf_done = bf_model | bf_extra;

   always @(negedge clk) begin
      if (bf_start) begin
         rd0_log[bs_cnt] = rd0;
         rd1_log[bs_cnt] = rd1;
         tw_log[bs_cnt]  = tw;
         bs_cnt++;
      end
      if (we) begin
         wr0_log[we_cnt] = wr0;
         wr1_log[we_cnt] = wr1;
         we_cnt++;
      end
      if (done) dn_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // start pulse: returns at the first negedge after acceptance (READ cycle)
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // k = negedges (from entry) until o_done is seen, -1 on expiry
   task automatic wait_done(input int max, output int k);
      k = 0;
      while (k < max) begin
         if (done) return;
         @(negedge clk);
         k++;
      end
      k = -1;
   endtask

   task automatic wait_bf_start(input int max, output int k);
      k = 0;
      while (k < max) begin
         @(negedge clk);
         k++;
         if (bf_start) return;
      end
      k = -1;
   endtask

   int bs0, we0, dn0, k, s, b, span, e0, e1, et;
   logic prev_we;

   initial begin
      rst = 1'b1; start = 1'b0; bf_extra = 1'b0; mode = 1;
      @(negedge clk); @(negedge clk);
      chk("reset_outs", {bf_start, we, done, busy, err, stage, rd0, rd1, wr0, wr1, tw}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", {busy, err, stage}, 0);

      // ---- nominal run
      bs0 = bs_cnt; we0 = we_cnt; dn0 = dn_cnt;
      pulse_start();
      chk("run_busy", busy, 1);
      chk("first_read", {stage, rd0, rd1, tw}, {2'd0, 4'd0, 4'd1, 3'd0});
      wait_done(300, k);
      chk("done_latency", k + 1, 129);
      @(negedge clk);
      chk("post_done", {busy, done, err}, 3'b000);
      chk("bf_start_count", bs_cnt - bs0, 32);
      chk("we_count", we_cnt - we0, 32);
      chk("done_count", dn_cnt - dn0, 1);
      chk("hold_in_idle", {stage, rd0, rd1}, {2'd3, 4'd7, 4'd15});
      chk("trace_s0b0", {rd0_log[bs0],    rd1_log[bs0],    tw_log[bs0]},    {4'd0, 4'd1,  3'd0});
      chk("trace_s1b1", {rd0_log[bs0+9],  rd1_log[bs0+9],  tw_log[bs0+9]},  {4'd1, 4'd3,  3'd4});
      chk("trace_s2b5", {rd0_log[bs0+21], rd1_log[bs0+21], tw_log[bs0+21]}, {4'd9, 4'd13, 3'd2});
      chk("trace_s3b7", {rd0_log[bs0+31], rd1_log[bs0+31], tw_log[bs0+31]}, {4'd7, 4'd15, 3'd7});
      for (int i = 0; i < 32; i++) begin
         s = i / 8; b = i % 8; span = 1 << s;
         e0 = (b / span) * 2 * span + (b % span);
         e1 = e0 + span;
         et = (b % span) * (8 / span);
         chk("read_addr", {rd0_log[bs0+i], rd1_log[bs0+i], tw_log[bs0+i]}, {e0[3:0], e1[3:0], et[2:0]});
         chk("write_addr", {wr0_log[we0+i], wr1_log[we0+i]}, {e0[3:0], e1[3:0]});
      end

      // ---- timeout
      mode = 0;
      we0 = we_cnt; dn0 = dn_cnt;
      pulse_start();
      wait_bf_start(5, k);
      chk("to_issue_seen", k > 0, 1);
      repeat (64) @(negedge clk);
      chk("to_wait64", {err, busy, we}, 3'b010);
      @(negedge clk);
      chk("to_error", {err, busy}, 2'b10);
      chk("to_no_we", we_cnt - we0, 0);
      chk("to_no_done", dn_cnt - dn0, 0);

      // ---- next start clears error; done coincident with timeout wins
      pulse_start();
      chk("err_cleared", err, 0);
      wait_bf_start(5, k);
      repeat (64) @(negedge clk);
      bf_extra = 1'b1;
      @(negedge clk);
      bf_extra = 1'b0;
      mode = 1;
      chk("done_wins", {we, err}, 2'b10);
      wait_done(300, k);
      chk("done_wins_finish", k > 0, 1);
      @(negedge clk);
      chk("done_wins_no_err", {err, busy}, 2'b00);

      // ---- reset mid-run at global butterfly 10 (s=1, b=2: 4/6)
      pulse_start();
      k = 0;
      while (k < 200 && !(bf_start && stage == 2'd1 && rd0 == 4'd4)) begin
         @(negedge clk);
         k++;
      end
      chk("reach_s1b2", k < 200, 1);
      we0 = we_cnt;
      rst = 1'b1;
      #1;
      chk("rst_midrun_outs", {bf_start, we, done, busy, err, stage, rd0, rd1, wr0, wr1, tw}, 0);
      @(negedge clk); @(negedge clk);
      chk("rst_no_write", we_cnt - we0, 0);
      rst = 1'b0;
      @(negedge clk);
      pulse_start();
      chk("restart_s0b0", {busy, stage, rd0, rd1, tw}, {1'b1, 2'd0, 4'd0, 4'd1, 3'd0});
      wait_done(300, k);
      chk("restart_latency", k + 1, 129);
      @(negedge clk);

      // ---- start held through a run, spurious done pulses in READ
      bs0 = bs_cnt; we0 = we_cnt; dn0 = dn_cnt;
      start = 1'b1;
      prev_we = 1'b0;
      k = 0;
      while (k < 300) begin
         @(negedge clk);
         k++;
         bf_extra = prev_we;
         prev_we  = we;
         if (done) break;
      end
      chk("held_latency", k, 129);
      // start stays high during DONE: must not restart from the DONE cycle
      start = 1'b0;
      bf_extra = 1'b0;
      repeat (3) @(negedge clk);
      chk("held_idle", busy, 0);
      chk("held_bf_starts", bs_cnt - bs0, 32);
      chk("held_wes", we_cnt - we0, 32);
      chk("held_dones", dn_cnt - dn0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
